// File: rtl/mem_access_pkg.sv
// Shared op codes, bus widths and FSM state encoding for the MEM pipeline stage.
package mem_access_pkg;

    localparam int MEM_OP_BUS   = 2;
    localparam int MEM_ADDR_BUS = 32;
    localparam int MEM_LEN_BUS  = 3;
    localparam int REG_BUS      = 5;
    localparam int WORD_BUS     = 32;

    localparam logic [MEM_OP_BUS-1:0] MEM_OP_NONE  = 2'd0;
    localparam logic [MEM_OP_BUS-1:0] MEM_OP_LOAD  = 2'd1;
    localparam logic [MEM_OP_BUS-1:0] MEM_OP_LOADU = 2'd2;
    localparam logic [MEM_OP_BUS-1:0] MEM_OP_STORE = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [MEM_OP_BUS-1:0]  i_op,
    input  logic [1:0]             i_offset,
    input  logic [MEM_LEN_BUS-1:0] i_len,
    input  logic [WORD_BUS-1:0]    i_wvalue,
    input  logic [WORD_BUS-1:0]    i_rdata,
    output logic                   o_legal,
    output logic [3:0]             o_be,
    output logic [WORD_BUS-1:0]    o_wdata,
    output logic [WORD_BUS-1:0]    o_rvalue
);

    logic [WORD_BUS-1:0] w_raw;
    logic                w_signed;

    always_comb begin
        w_raw    = i_rdata >> {i_offset, 3'b000};
        w_signed = (i_op == MEM_OP_LOAD);
        o_legal  = 1'b0;
        o_be     = 4'b0000;
        o_wdata  = i_wvalue;
        o_rvalue = w_raw;
        case (i_len)
            3'd1: begin
                o_legal  = 1'b1;
                o_be     = 4'b0001 << i_offset;
                o_wdata  = {4{i_wvalue[7:0]}};
                o_rvalue = {{24{w_signed & w_raw[7]}}, w_raw[7:0]};
            end
            3'd2: begin
                o_legal  = ~i_offset[0];
                o_be     = 4'b0011 << i_offset;
                o_wdata  = {2{i_wvalue[15:0]}};
                o_rvalue = {{16{w_signed & w_raw[15]}}, w_raw[15:0]};
            end
            3'd4: begin
                o_legal  = (i_offset == 2'b00);
                o_be     = 4'b1111;
                o_wdata  = i_wvalue;
                o_rvalue = w_raw;
            end
            default: begin
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: runs one req/ack data-memory transaction per op, stalling upstream
// until the DONE cycle, where write-back data is presented for MEM/WB.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MEM_OP_BUS-1:0]   mem_memOp,
    input  logic [MEM_ADDR_BUS-1:0] mem_memAddr,
    input  logic [MEM_LEN_BUS-1:0]  mem_memLen,
    input  logic [REG_BUS-1:0]      mem_regDest,
    input  logic [WORD_BUS-1:0]     mem_value,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [MEM_ADDR_BUS-1:0] dmem_addr,
    output logic [3:0]              dmem_be,
    output logic [WORD_BUS-1:0]     dmem_wdata,
    input  logic [WORD_BUS-1:0]     dmem_rdata,
    input  logic                    dmem_ack,
    output logic                    stall_req,
    output logic [REG_BUS-1:0]      wb_regDest,
    output logic [WORD_BUS-1:0]     wb_value,
    output logic                    wb_we,
    output logic                    misalign,
    output logic                    bus_err
);

    state_e              r_state, w_state_next;
    logic                r_req, w_req_next;
    logic                r_err, w_err_next;
    logic [31:0]         r_cnt, w_cnt_next;
    logic [WORD_BUS-1:0] r_rdata, w_rdata_next;

    logic                w_memop, w_legal, w_go, w_timeout;
    logic [3:0]          w_be;
    logic [WORD_BUS-1:0] w_wdata, w_rvalue;

    mem_align u_align (
        .i_op     (mem_memOp),
        .i_offset (mem_memAddr[1:0]),
        .i_len    (mem_memLen),
        .i_wvalue (mem_value),
        .i_rdata  (r_rdata),
        .o_legal  (w_legal),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_rvalue (w_rvalue)
    );

    assign w_memop   = (mem_memOp != MEM_OP_NONE);
    assign w_go      = w_memop & w_legal;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_req   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_req   <= w_req_next;
            r_err   <= w_err_next;
            r_cnt   <= w_cnt_next;
            r_rdata <= w_rdata_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_next   = r_req;
        w_err_next   = r_err;
        w_cnt_next   = r_cnt;
        w_rdata_next = r_rdata;
        unique case (r_state)
            StIdle: begin
                w_cnt_next = '0;
                w_err_next = 1'b0;
                if (w_go) begin
                    w_state_next = StBusy;
                    w_req_next   = 1'b1;
                end
            end
            StBusy: begin
                if (dmem_ack) begin
                    w_state_next = StDone;
                    w_req_next   = 1'b0;
                    w_rdata_next = dmem_rdata;
                    w_cnt_next   = '0;
                end else if (w_timeout) begin
                    w_state_next = StDone;
                    w_req_next   = 1'b0;
                    w_err_next   = 1'b1;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            StDone: begin
                w_state_next = StIdle;
                w_err_next   = 1'b0;
            end
            default: begin
                w_state_next = StIdle;
                w_req_next   = 1'b0;
            end
        endcase
    end

    always_comb begin
        stall_req  = 1'b0;
        wb_we      = 1'b0;
        wb_value   = '0;
        wb_regDest = mem_regDest;
        misalign   = w_memop & ~w_legal;
        unique case (r_state)
            StIdle: begin
                if (!w_memop) begin
                    wb_value = mem_value;
                    wb_we    = |mem_regDest;
                end else if (w_legal) begin
                    stall_req = 1'b1;
                end
            end
            StBusy: stall_req = 1'b1;
            StDone: begin
                // Stores and timed-out accesses retire without a register write.
                if (!r_err && mem_memOp != MEM_OP_STORE) begin
                    wb_value = w_rvalue;
                    wb_we    = |mem_regDest;
                end
            end
            default: stall_req = 1'b0;
        endcase
    end

    assign dmem_req   = r_req;
    assign dmem_we    = (mem_memOp == MEM_OP_STORE);
    assign dmem_addr  = {mem_memAddr[31:2], 2'b00};
    assign dmem_be    = w_be;
    assign dmem_wdata = w_wdata;
    assign bus_err    = r_err;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: the driver queues expected bus and write-back results,
// a negedge monitor pops and compares them as the DUT presents each one.
module tb_mem_access;

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_LOADU = 2'd2;
    localparam logic [1:0] OP_STORE = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mem_memOp;
    logic [31:0] mem_memAddr;
    logic [2:0]  mem_memLen;
    logic [4:0]  mem_regDest;
    logic [31:0] mem_value;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall_req;
    logic [4:0]  wb_regDest;
    logic [31:0] wb_value;
    logic        wb_we, misalign, bus_err;

    mem_access #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_memOp   (mem_memOp),
        .mem_memAddr (mem_memAddr),
        .mem_memLen  (mem_memLen),
        .mem_regDest (mem_regDest),
        .mem_value   (mem_value),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .stall_req   (stall_req),
        .wb_regDest  (wb_regDest),
        .wb_value    (wb_value),
        .wb_we       (wb_we),
        .misalign    (misalign),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] val;
        logic        chk_val;
        logic [4:0]  rd;
        logic        mis;
        logic        err;
        int          stall;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic op_valid = 1'b0;
    logic prev_req = 1'b0;
    int   stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic expect_wb(input logic we, input logic [31:0] val, input logic chk_val,
                             input logic [4:0] rd, input logic mis, input logic err,
                             input int stall);
        exp_t e;
        e.we = we; e.val = val; e.chk_val = chk_val; e.rd = rd;
        e.mis = mis; e.err = err; e.stall = stall;
        exp_q.push_back(e);
    endtask

    task automatic expect_bus(input logic [31:0] addr, input logic [3:0] be, input logic we,
                              input logic [31:0] wdata);
        bus_t b;
        b.addr = addr; b.be = be; b.we = we; b.wdata = wdata;
        bus_q.push_back(b);
    endtask

    // Monitor: bus fields on each rising request, write-back on each unstalled op cycle.
    always @(negedge clk) begin
        exp_t e;
        bus_t b;
        if (dmem_req && !prev_req) begin
            if (bus_q.size() == 0) begin
                check("unexpected_req", 32'd1, 32'd0);
            end else begin
                b = bus_q.pop_front();
                check("dmem_addr", dmem_addr, b.addr);
                check("dmem_be", {28'd0, dmem_be}, {28'd0, b.be});
                check("dmem_we", {31'd0, dmem_we}, {31'd0, b.we});
                if (b.we) check("dmem_wdata", dmem_wdata, b.wdata);
            end
        end
        prev_req <= dmem_req;
        if (op_valid) begin
            if (stall_req) begin
                stall_cnt <= stall_cnt + 1;
            end else begin
                if (exp_q.size() == 0) begin
                    check("no_expectation", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_we", {31'd0, wb_we}, {31'd0, e.we});
                    if (e.chk_val) check("wb_value", wb_value, e.val);
                    check("wb_regDest", {27'd0, wb_regDest}, {27'd0, e.rd});
                    check("misalign", {31'd0, misalign}, {31'd0, e.mis});
                    check("bus_err", {31'd0, bus_err}, {31'd0, e.err});
                    check("req_low_at_done", {31'd0, dmem_req}, 32'd0);
                    check("stall_cycles", stall_cnt, e.stall);
                end
                stall_cnt <= 0;
            end
        end
    end

    // Drive one op; ack_wait = BUSY cycles before ack (-1: never ack).
    task automatic run_op(input logic [1:0] op, input logic [31:0] addr, input logic [2:0] len,
                          input logic [4:0] rd, input logic [31:0] val, input int ack_wait,
                          input logic [31:0] rdata);
        int  k = 0;
        logic done = 1'b0;
        mem_memOp   = op;
        mem_memAddr = addr;
        mem_memLen  = len;
        mem_regDest = rd;
        mem_value   = val;
        op_valid    = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!stall_req) begin
                done = 1'b1;
            end else if (dmem_req) begin
                dmem_ack   = (k == ack_wait);
                dmem_rdata = (k == ack_wait) ? rdata : 32'h0BAD_0BAD;
                k++;
            end
        end
        check("op_completes", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        mem_memOp = OP_NONE; mem_memAddr = '0; mem_memLen = 3'd0;
        mem_regDest = '0; mem_value = '0; dmem_rdata = '0; dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_req", {31'd0, dmem_req}, 32'd0);
        check("reset_stall", {31'd0, stall_req}, 32'd0);
        check("reset_bus_err", {31'd0, bus_err}, 32'd0);
        check("reset_wb_we", {31'd0, wb_we}, 32'd0);
        @(posedge clk);
        #1;

        // NONE pass-through
        expect_wb(1'b1, 32'h0000_1234, 1'b1, 5'd5, 1'b0, 1'b0, 0);
        run_op(OP_NONE, 32'h0, 3'd4, 5'd5, 32'h0000_1234, 0, 32'h0);
        // STORE byte to lane 3, two wait cycles
        expect_bus(32'h0000_1000, 4'b1000, 1'b1, 32'hABAB_ABAB);
        expect_wb(1'b0, 32'h0, 1'b0, 5'd7, 1'b0, 1'b0, 4);
        run_op(OP_STORE, 32'h0000_1003, 3'd1, 5'd7, 32'h0000_00AB, 2, 32'h0);
        // LOAD / LOADU half from upper lanes
        expect_bus(32'h0000_2000, 4'b1100, 1'b0, 32'h0);
        expect_wb(1'b1, 32'hFFFF_8001, 1'b1, 5'd3, 1'b0, 1'b0, 2);
        run_op(OP_LOAD, 32'h0000_2002, 3'd2, 5'd3, 32'h0, 0, 32'h8001_0000);
        expect_bus(32'h0000_2000, 4'b1100, 1'b0, 32'h0);
        expect_wb(1'b1, 32'h0000_8001, 1'b1, 5'd3, 1'b0, 1'b0, 2);
        run_op(OP_LOADU, 32'h0000_2002, 3'd2, 5'd3, 32'h0, 0, 32'h8001_0000);
        // Misaligned and illegal-length accesses
        expect_wb(1'b0, 32'h0, 1'b0, 5'd6, 1'b1, 1'b0, 0);
        run_op(OP_LOAD, 32'h0000_3001, 3'd4, 5'd6, 32'h0, 0, 32'h0);
        expect_wb(1'b0, 32'h0, 1'b0, 5'd6, 1'b1, 1'b0, 0);
        run_op(OP_LOAD, 32'h0000_9000, 3'd3, 5'd6, 32'h0, 0, 32'h0);
        expect_wb(1'b0, 32'h0, 1'b0, 5'd6, 1'b1, 1'b0, 0);
        run_op(OP_STORE, 32'h0000_9001, 3'd2, 5'd6, 32'h1111_2222, 0, 32'h0);
        // Timeout: no ack, four BUSY cycles then bus error
        expect_bus(32'h0000_5000, 4'b1111, 1'b0, 32'h0);
        expect_wb(1'b0, 32'h0, 1'b1, 5'd9, 1'b0, 1'b1, 5);
        run_op(OP_LOAD, 32'h0000_5000, 3'd4, 5'd9, 32'h0, -1, 32'h0);
        // Signed byte load, one wait cycle
        expect_bus(32'h0000_6000, 4'b0010, 1'b0, 32'h0);
        expect_wb(1'b1, 32'hFFFF_FF80, 1'b1, 5'd8, 1'b0, 1'b0, 3);
        run_op(OP_LOAD, 32'h0000_6001, 3'd1, 5'd8, 32'h0, 1, 32'h0000_8000);
        // Half and word stores
        expect_bus(32'h0000_7000, 4'b1100, 1'b1, 32'h5678_5678);
        expect_wb(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 2);
        run_op(OP_STORE, 32'h0000_7002, 3'd2, 5'd0, 32'h1234_5678, 0, 32'h0);
        expect_bus(32'h0000_8000, 4'b1111, 1'b1, 32'hCAFE_F00D);
        expect_wb(1'b0, 32'h0, 1'b0, 5'd1, 1'b0, 1'b0, 2);
        run_op(OP_STORE, 32'h0000_8000, 3'd4, 5'd1, 32'hCAFE_F00D, 0, 32'h0);
        // Word load to r0 and NONE to r0: data present, no write
        expect_bus(32'h0000_A000, 4'b1111, 1'b0, 32'h0);
        expect_wb(1'b0, 32'h1122_3344, 1'b1, 5'd0, 1'b0, 1'b0, 2);
        run_op(OP_LOAD, 32'h0000_A000, 3'd4, 5'd0, 32'h0, 0, 32'h1122_3344);
        expect_wb(1'b0, 32'h0000_0055, 1'b1, 5'd0, 1'b0, 1'b0, 0);
        run_op(OP_NONE, 32'h0, 3'd0, 5'd0, 32'h0000_0055, 0, 32'h0);
        op_valid = 1'b0;

        // Reset mid-BUSY, then a late ack that must be ignored
        expect_bus(32'h0000_4000, 4'b1111, 1'b0, 32'h0);
        mem_memOp = OP_LOAD; mem_memAddr = 32'h0000_4000; mem_memLen = 3'd4; mem_regDest = 5'd2;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_busy", {31'd0, dmem_req}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        mem_memOp = OP_NONE; mem_regDest = 5'd0;
        @(posedge clk);
        #1 rst = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        @(posedge clk);
        #1 dmem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_req", {31'd0, dmem_req}, 32'd0);
        check("late_ack_stall", {31'd0, stall_req}, 32'd0);
        check("late_ack_wb_we", {31'd0, wb_we}, 32'd0);
        @(posedge clk);
        #1;

        // Clean transaction after reset
        expect_bus(32'h0000_B000, 4'b1000, 1'b0, 32'h0);
        expect_wb(1'b1, 32'h0000_00F0, 1'b1, 5'd4, 1'b0, 1'b0, 2);
        run_op(OP_LOADU, 32'h0000_B003, 3'd1, 5'd4, 32'h0, 0, 32'hF000_0000);
        op_valid = 1'b0;
        mem_memOp = OP_NONE;

        @(negedge clk);
        check("exp_queue_empty", exp_q.size(), 32'd0);
        check("bus_queue_empty", bus_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
